// File: rtl/rv_regfile_sb.sv
// Multi-port integer register file with per-register busy scoreboard.
// Ports: clk, reset_n, raddr/rdata/rbusy (NRD), we/waddr/wdata (NWR),
//        iss_valid/iss_rd, flush, busy_cnt, any_busy.
module rv_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS),
  parameter int CW     = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  output logic [CW-1:0]     busy_cnt,
  output logic              any_busy
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;

  logic [AW-1:0]    ra;
  logic [XLEN-1:0]  rd;
  logic             hit;

  // mem[0] is reset and never written, so it reads as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++) mem[k] <= '0;
    end else begin
      // Ascending order: the highest-index port wins.
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && waddr[j*AW +: AW] != '0)
          mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    hit   = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra  = raddr[i*AW +: AW];
      rd  = mem[ra];
      hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (BYPASS != 0 && we[j] && ra != '0 &&
            waddr[j*AW +: AW] == ra) begin
          rd  = wdata[j*XLEN +: XLEN];
          hit = 1'b1;
        end
      end
      rdata[i*XLEN +: XLEN] = rd;
      rbusy[i] = busy[ra] & ~hit;
    end
  end

  // Clear on writeback, then set on issue so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && waddr[j*AW +: AW] != '0)
        busy_nxt[waddr[j*AW +: AW]] = 1'b0;
    end
    if (iss_valid && iss_rd != '0)
      busy_nxt[iss_rd] = 1'b1;
    if (flush)
      busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < NREGS; k++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[k]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign any_busy = busy_cnt != '0;

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed bench for rv_regfile_sb: bypassing dual-write instance
// plus a non-bypassing single-write instance on shared stimulus.
module tb_rv_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2*AW-1:0] raddr;
  logic [2*XLEN-1:0] rdata, rdata_nb;
  logic [1:0]      rbusy, rbusy_nb;
  logic [1:0]      we;
  logic [2*AW-1:0] waddr;
  logic [2*XLEN-1:0] wdata;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            flush;
  logic [CW-1:0]   busy_cnt, busy_cnt_nb;
  logic            any_busy, any_busy_nb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_regfile_sb #(.NWR(2), .BYPASS(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .busy_cnt(busy_cnt), .any_busy(any_busy)
  );

  rv_regfile_sb #(.NWR(1), .BYPASS(0)) u_nb (
    .clk(clk), .reset_n(reset_n),
    .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we[0:0]), .waddr(waddr[AW-1:0]), .wdata(wdata[XLEN-1:0]),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .busy_cnt(busy_cnt_nb), .any_busy(any_busy_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = '0;
    iss_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a,
                    input logic [XLEN-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_valid = 1'b1;
    iss_rd = a;
  endtask

  initial begin
    reset_n = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; iss_rd = '0;
    idle();
    #3;
    chk("reset_cnt", 32'(busy_cnt), 0);
    chk("reset_any", 32'(any_busy), 0);
    #9 reset_n = 1'b1;
    tick();

    wr(0, 5, 32'hDEADBEEF);
    tick(); idle();
    raddr[0 +: AW] = 5;
    #1;
    chk("x5_rd", rdata[31:0], 32'hDEADBEEF);
    chk("x5_busy", 32'(rbusy[0]), 0);
    chk("x5_rd_nb", rdata_nb[31:0], 32'hDEADBEEF);

    wr(0, 0, 32'h1234);
    tick(); idle();
    raddr[0 +: AW] = 0;
    #1;
    chk("x0_rd", rdata[31:0], 0);
    chk("x0_busy", 32'(rbusy[0]), 0);

    wr(0, 7, 32'hA5A5A5A5);
    raddr[AW +: AW] = 7;
    #1;
    chk("byp_rd", rdata[63:32], 32'hA5A5A5A5);
    chk("nobyp_rd", rdata_nb[63:32], 0);
    tick(); idle();
    #1;
    chk("nobyp_late", rdata_nb[63:32], 32'hA5A5A5A5);

    issue(3);
    tick(); idle();
    raddr[0 +: AW] = 3;
    #1;
    chk("x3_busy", 32'(rbusy[0]), 1);
    chk("x3_cnt", 32'(busy_cnt), 1);
    chk("x3_any", 32'(any_busy), 1);
    chk("x3_busy_nb", 32'(rbusy_nb[0]), 1);
    wr(0, 3, 32'h11);
    #1;
    chk("wb_rd", rdata[31:0], 32'h11);
    chk("wb_busy", 32'(rbusy[0]), 0);
    chk("wb_busy_nb", 32'(rbusy_nb[0]), 1);
    chk("wb_rd_nb", rdata_nb[31:0], 0);
    tick(); idle();
    #1;
    chk("wb_cnt", 32'(busy_cnt), 0);
    chk("wb_rd_after", rdata[31:0], 32'h11);

    issue(4);
    wr(0, 4, 32'h22);
    tick(); idle();
    raddr[0 +: AW] = 4;
    #1;
    chk("x4_rd", rdata[31:0], 32'h22);
    chk("x4_busy", 32'(rbusy[0]), 1);
    chk("x4_cnt", 32'(busy_cnt), 1);

    wr(0, 9, 32'h1);
    wr(1, 9, 32'h2);
    raddr[AW +: AW] = 9;
    #1;
    chk("x9_byp", rdata[63:32], 32'h2);
    tick(); idle();
    raddr[0 +: AW] = 9;
    #1;
    chk("x9_rd", rdata[31:0], 32'h2);

    issue(1); tick();
    issue(2); tick();
    issue(3); tick(); idle();
    #1;
    chk("pre_flush_cnt", 32'(busy_cnt), 4);
    flush = 1'b1;
    issue(4);
    wr(0, 10, 32'h77);
    tick(); idle();
    raddr[AW +: AW] = 10;
    #1;
    chk("flush_cnt", 32'(busy_cnt), 0);
    chk("flush_any", 32'(any_busy), 0);
    chk("flush_x9", rdata[31:0], 32'h2);
    chk("flush_x10", rdata[63:32], 32'h77);

    issue(0);
    tick(); idle();
    #1;
    chk("iss_x0_cnt", 32'(busy_cnt), 0);

    issue(1); tick();
    issue(2); tick();
    issue(3); tick(); idle();
    raddr[0 +: AW] = 5;
    raddr[AW +: AW] = 1;
    #1;
    chk("pre_rst_cnt", 32'(busy_cnt), 3);
    chk("pre_rst_busy", 32'(rbusy[1]), 1);
    chk("pre_rst_x5", rdata[31:0], 32'hDEADBEEF);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_cnt", 32'(busy_cnt), 0);
    chk("rst_any", 32'(any_busy), 0);
    chk("rst_busy", 32'(rbusy[1]), 0);
    chk("rst_x5", rdata[31:0], 0);
    chk("rst_cnt_nb", 32'(busy_cnt_nb), 0);
    #10 reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_regfile_sb.md
Name: rv_regfile_sb

Overview:
Parametrised multi-port integer register file with an integrated scoreboard, for the pipelined RV32I core and for wider or multi-issue variants. It provides NRD read ports and NWR write ports, with optional write-to-read bypass. Per-register busy bits track outstanding producers between issue and writeback. x0 is hardwired to zero and is never busy.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers including x0; power of two, at least 2
- NRD, 2, number of read ports
- NWR, 1, number of write ports
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return array contents only
- Derived: AW = $clog2(NREGS); CW = $clog2(NREGS+1)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rdata  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- rbusy  out  NRD  read port i targets a register with a pending producer
- we  in  NWR  write enables
- waddr  in  NWR*AW  write addresses
- wdata  in  NWR*XLEN  write data
- iss_valid  in  1  an instruction that writes iss_rd is issuing this cycle
- iss_rd  in  AW  destination register of the issuing instruction
- flush  in  1  clear all busy bits; register contents are unaffected
- busy_cnt  out  CW  number of busy registers, registered
- any_busy  out  1  busy_cnt != 0

Behaviour:
- Reset (async assert, sync release): all registers 1..NREGS-1 = 0, all busy bits = 0, busy_cnt = 0.
- Writes: on the clock edge, each port j with we[j]=1 and waddr[j]!=0 writes wdata[j]. Writes to x0 are dropped.
- Multiple write ports, same address, same cycle: the highest-index port wins.
- Reads are combinational. raddr=0 returns 0 and rbusy=0.
- BYPASS=1: if any port j has we[j]=1 and waddr[j]==raddr[i]!=0, then rdata[i] = wdata of the highest matching j. Otherwise rdata[i] is the array value.
- BYPASS=0: rdata[i] is always the stored value. A write is visible on the cycle after it occurs.
- Busy bit set: iss_valid=1 and iss_rd!=0 set busy[iss_rd] at the edge. Issuing x0 is ignored.
- Busy bit clear: any we[j]=1 with waddr[j]!=0 clears busy[waddr[j]] at the edge.
- Issue and writeback to the same register in the same cycle: the set wins, so the register stays busy (a new producer exists).
- flush=1 clears all busy bits at the edge and overrides same-cycle issue. Writes still occur in a flush cycle.
- rbusy[i], BYPASS=1: busy[raddr[i]] AND NOT (a same-cycle write hits raddr[i]).
- rbusy[i], BYPASS=0: busy[raddr[i]] only.
- rbusy does not reflect a same-cycle issue; the new busy bit is visible from the next cycle.
- busy_cnt: registered population count of the next-state busy vector, so it always equals popcount(busy) in the same cycle. Maximum value NREGS-1.
- Reset mid-operation: contents, busy bits and count clear immediately. Outputs are valid combinationally from the reset state.
- No X propagation: addresses at or above NREGS cannot occur since NREGS is a power of two.

Test Plan:
- Reset, then write x5=0xDEADBEEF (port 0). Next cycle raddr0=5 gives rdata0=0xDEADBEEF and rbusy0=0. A write of x0=0x1234 is followed by a read of x0 giving 0.
- BYPASS=1: we=1, waddr=7, wdata=0xA5A5A5A5 while raddr1=7 gives rdata1=0xA5A5A5A5 in the same cycle. With BYPASS=0, the same stimulus returns the old value (0).
- Issue x3: next cycle rbusy=1 for x3 and busy_cnt=1. Writeback x3=0x11 with BYPASS=1 gives rbusy=0 and rdata=0x11 in the writeback cycle. Next cycle busy_cnt=0.
- Same-cycle issue x4 and write x4=0x22: next cycle x4 reads 0x22, rbusy=1, busy_cnt=1.
- NWR=2, both ports write x9 (0x1 on port 0, 0x2 on port 1): x9 reads 0x2. Issue x1, x2, x3, then flush with a simultaneous issue of x4: next cycle busy_cnt=0, any_busy=0, and register contents are unchanged.
- Assert reset_n=0 asynchronously mid-cycle with 3 busy registers and x5 nonzero: busy_cnt=0, rbusy=0 and x5 reads 0 immediately, before the next clock edge.
